// File: rtl/uart_dmem_loader.sv
// uart_dmem_loader: receives a UART word stream and writes it into data RAM while the CPU is held
// Ports:
//   i_clk, i_rstn         clock, asynchronous active-low reset
//   i_enable              loader active (tied to !start at the top level)
//   i_rx                  UART serial input, idle high, asynchronous to i_clk
//   o_mem_addr/o_mem_wdata/o_mem_we   dmem write port, one-cycle strobe per word
//   o_word_count          words written in the current load
//   o_busy/o_done/o_err   load in progress, all words written, sticky error (01 framing, 10 length)
module uart_dmem_loader #(
    parameter int          CLK_FREQ  = 100000000,
    parameter int          BAUD      = 115200,
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_enable,
    input  logic        i_rx,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_we,
    output logic [15:0] o_word_count,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_err
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
    localparam logic [15:0] MAXW = 16'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_HDR0, L_HDR1, L_DATA, L_WRITE, L_DONE, L_ERROR} ld_state_t;

    logic            r_rx_s1, r_rx_s2, r_rx_s3;
    rx_state_t       r_rx_state, w_rx_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_byte_valid, r_frame_err;
    ld_state_t       r_state, w_next;
    logic            r_en_d;
    logic [15:0]     r_n, r_count;
    logic [31:0]     r_word, r_addr;
    logic [1:0]      r_idx, r_err;
    logic            w_fall, w_half, w_tick, w_cnt_clr, w_busy_st;
    logic [15:0]     w_hdr_n;

    // r_rx_s3 is only the previous synchronized sample, used for falling-edge detection
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    assign w_fall = r_rx_s3 & ~r_rx_s2;
    assign w_half = r_cnt == HALF_M1;
    assign w_tick = r_cnt == DIV_M1;
    assign w_cnt_clr = (r_rx_state == RX_IDLE) | ((r_rx_state == RX_START) & w_half) | w_tick;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_rx_state <= RX_IDLE;
        else         r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  w_rx_next = w_fall ? RX_START : RX_IDLE;
            RX_START: w_rx_next = w_half ? (r_rx_s2 ? RX_IDLE : RX_DATA) : RX_START;
            RX_DATA:  w_rx_next = (w_tick && r_bit == 3'd7) ? RX_STOP : RX_DATA;
            RX_STOP:  w_rx_next = w_tick ? RX_IDLE : RX_STOP;
            default:  w_rx_next = RX_IDLE;
        endcase
        if (!i_enable) w_rx_next = RX_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt        <= '0;
            r_bit        <= 3'd0;
            r_shift      <= 8'd0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_cnt        <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            if (r_rx_state == RX_IDLE) r_bit <= 3'd0;
            if (r_rx_state == RX_DATA && w_tick) begin
                r_shift <= {r_rx_s2, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (r_rx_state == RX_STOP && w_tick && i_enable) begin
                r_byte_valid <= r_rx_s2;
                r_frame_err  <= ~r_rx_s2;
            end
        end
    end

    assign w_hdr_n = {r_shift, r_n[7:0]};
    assign w_busy_st = (r_state == L_HDR0) | (r_state == L_HDR1) | (r_state == L_DATA) | (r_state == L_WRITE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= L_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            L_IDLE:  if (i_enable && !r_en_d) w_next = L_HDR0;
            L_HDR0:  if (r_byte_valid) w_next = L_HDR1;
            L_HDR1:  if (r_byte_valid) w_next = (w_hdr_n == 16'd0) ? L_DONE : (w_hdr_n > MAXW) ? L_ERROR : L_DATA;
            L_DATA:  if (r_byte_valid && r_idx == 2'd3) w_next = L_WRITE;
            L_WRITE: w_next = (r_count + 16'd1 == r_n) ? L_DONE : L_DATA;
            default: w_next = r_state;
        endcase
        if (w_busy_st && r_frame_err) w_next = L_ERROR;
        if (!i_enable) w_next = L_IDLE;
    end

    always_comb begin
        o_busy       = w_busy_st;
        o_done       = r_state == L_DONE;
        o_mem_we     = (r_state == L_WRITE) & i_enable;
        o_mem_addr   = r_addr;
        o_mem_wdata  = r_word;
        o_word_count = r_count;
        o_err        = r_err;
    end

    // word_count survives IDLE so it can be inspected; it is cleared only when a new load starts
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_en_d  <= 1'b0;
            r_n     <= 16'd0;
            r_word  <= 32'd0;
            r_idx   <= 2'd0;
            r_count <= 16'd0;
            r_addr  <= ADDR_BASE;
            r_err   <= 2'b00;
        end else begin
            r_en_d <= i_enable;
            if (r_state == L_IDLE) begin
                r_word <= 32'd0;
                r_idx  <= 2'd0;
                r_err  <= 2'b00;
                r_addr <= ADDR_BASE;
                if (w_next == L_HDR0) r_count <= 16'd0;
            end else if (i_enable) begin
                if (r_byte_valid) begin
                    if (r_state == L_HDR0) r_n[7:0] <= r_shift;
                    if (r_state == L_HDR1) begin
                        r_n[15:8] <= r_shift;
                        r_idx     <= 2'd0;
                        if (w_hdr_n > MAXW) r_err <= 2'b10;
                    end
                    if (r_state == L_DATA) begin
                        r_word[{r_idx, 3'b000} +: 8] <= r_shift;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) r_addr <= ADDR_BASE + {14'd0, r_count, 2'b00};
                    end
                end
                if (r_state == L_WRITE) begin
                    r_count <= r_count + 16'd1;
                    r_idx   <= 2'd0;
                end
                if (w_busy_st && r_frame_err) r_err <= 2'b01;
            end
        end
    end
endmodule

// File: tb/tb_uart_dmem_loader.sv
// tb_uart_dmem_loader: scoreboard bench for the UART dmem loader with randomized word streams
module tb_uart_dmem_loader;
    localparam int DIV = 16;
    localparam logic [31:0] ABASE = 32'h0000_0200;
    localparam int MAXW = 1024;

    logic        clk = 1'b0;
    logic        rstn, enable, rx;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we, busy, done;
    logic [15:0] word_count;
    logic [1:0]  err;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t        q[$];
    logic [31:0] g_words[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    uart_dmem_loader #(.CLK_FREQ(16), .BAUD(1), .ADDR_BASE(ABASE), .MAX_WORDS(MAXW)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_enable(enable), .i_rx(rx),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
        .o_word_count(word_count), .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // every write strobe must match the oldest expected write, including the cycle it lands on
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual addr=%h data=%h cyc=%0d required no write", mem_addr, mem_wdata, cyc);
            end else begin
                e = q.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d || cyc != e.c) begin
                    failures++;
                    $display("FAIL write actual addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                             mem_addr, mem_wdata, cyc, e.a, e.d, e.c);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".addr"}, mem_addr, ABASE);
        chk({tag, ".wdata"}, mem_wdata, 32'd0);
        chk({tag, ".we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, ".count"}, {16'd0, word_count}, 32'd0);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".done"}, {31'd0, done}, 32'd0);
        chk({tag, ".err"}, {30'd0, err}, 32'd0);
    endtask

    // launches a full 10-bit frame; when push is set the write is due one cycle after the stop sample
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic push, input logic [31:0] a, input logic [31:0] d);
        int k;
        exp_t e;
        @(posedge clk);
        #1 rx = 1'b0;
        k = cyc;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (DIV) @(posedge clk);
        end
        #1 rx = stop;
        if (push) begin
            e.a = a;
            e.d = d;
            e.c = k + 9 * DIV + DIV / 2 + 4;
            q.push_back(e);
        end
        repeat (DIV) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    // reference model: header N then g_words; only the first N words of an accepted load are written
    task automatic send_load(input string tag, input logic [15:0] n);
        int          nn, sent, ok;
        logic [31:0] w;
        nn = int'(n);
        sent = g_words.size();
        ok = (nn != 0 && nn <= MAXW) ? 1 : 0;
        send_byte(n[7:0], 1'b1, 1'b0, 32'd0, 32'd0);
        send_byte(n[15:8], 1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < sent; i++) begin
            w = g_words[i];
            for (int j = 0; j < 4; j++)
                send_byte(w[8*j +: 8], 1'b1, (j == 3 && ok == 1 && i < nn), ABASE + 32'(4 * i), w);
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, ".count"}, {16'd0, word_count}, (ok == 1) ? 32'(sent < nn ? sent : nn) : 32'd0);
        chk({tag, ".done"}, {31'd0, done}, 32'(nn == 0 || (ok == 1 && sent >= nn)));
        chk({tag, ".busy"}, {31'd0, busy}, 32'(ok == 1 && sent < nn));
        chk({tag, ".err"}, {30'd0, err}, (nn > MAXW) ? 32'd2 : 32'd0);
    endtask

    task automatic restart();
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        int          n;
        rstn = 1'b0;
        enable = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset("reset");
        rstn = 1'b1;
        @(posedge clk);
        #1 enable = 1'b1;
        repeat (3) @(posedge clk);

        g_words = '{32'h12345678, 32'hDEADBEEF};
        send_load("basic", 16'd2);
        chk("basic.addr_hold", mem_addr, ABASE + 32'd4);
        chk("basic.wdata_hold", mem_wdata, 32'hDEADBEEF);
        send_byte(8'hAA, 1'b1, 1'b0, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        #1 chk("done_ignore.count", {16'd0, word_count}, 32'd2);
        chk("done_ignore.done", {31'd0, done}, 32'd1);

        restart();
        g_words.delete();
        send_load("zero", 16'd0);

        restart();
        send_load("length", 16'd1025);
        restart();
        chk("relaunch.err", {30'd0, err}, 32'd0);
        chk("relaunch.busy", {31'd0, busy}, 32'd1);
        g_words = '{$urandom, $urandom, $urandom};
        send_load("relaunch", 16'd3);

        restart();
        w = $urandom;
        send_byte(8'd4, 1'b1, 1'b0, 32'd0, 32'd0);
        send_byte(8'd0, 1'b1, 1'b0, 32'd0, 32'd0);
        for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b1, j == 3, ABASE, w);
        send_byte(8'h55, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int j = 0; j < 4; j++) send_byte(8'(j + 1), 1'b1, 1'b0, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        #1 chk("framing.err", {30'd0, err}, 32'd1);
        chk("framing.busy", {31'd0, busy}, 32'd0);
        chk("framing.done", {31'd0, done}, 32'd0);
        chk("framing.count", {16'd0, word_count}, 32'd1);

        restart();
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        #1 chk("glitch.err", {30'd0, err}, 32'd0);
        chk("glitch.busy", {31'd0, busy}, 32'd1);
        g_words = '{$urandom};
        send_load("glitch", 16'd1);

        restart();
        w = $urandom;
        send_byte(8'd2, 1'b1, 1'b0, 32'd0, 32'd0);
        send_byte(8'd0, 1'b1, 1'b0, 32'd0, 32'd0);
        for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b1, j == 3, ABASE, w);
        send_byte(8'h11, 1'b1, 1'b0, 32'd0, 32'd0);
        send_byte(8'h22, 1'b1, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (6 * DIV) @(posedge clk);
        #1 chk("drop.count", {16'd0, word_count}, 32'd1);
        chk("drop.busy", {31'd0, busy}, 32'd0);
        chk("drop.done", {31'd0, done}, 32'd0);

        for (int r = 0; r < 3; r++) begin
            restart();
            n = int'($urandom_range(1, 4));
            g_words.delete();
            for (int i = 0; i < n; i++) g_words.push_back($urandom);
            send_load($sformatf("rand%0d", r), 16'(n));
        end

        restart();
        send_byte(8'd1, 1'b1, 1'b0, 32'd0, 32'd0);
        send_byte(8'd0, 1'b1, 1'b0, 32'd0, 32'd0);
        for (int j = 0; j < 3; j++) send_byte(8'($urandom), 1'b1, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (5 * DIV) @(posedge clk);
        #1 rstn = 1'b0;
        #1 chk_reset("midreset");
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (20 * DIV) @(posedge clk);
        #1 chk("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
